// File: rtl/usadd_pkg.sv
// usadd_pkg: shared state encoding plus frame-length and clog2 helpers for the unary adder scheduler
package usadd_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;
  function automatic int frame_len(input int bw);
    return 1 << bw;
  endfunction
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/usadd_frame_sched_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant searching from ptr+1 (i_req -> o_gnt/o_idx/o_any), ptr moves to the winner on i_en
module rr_arbiter import usadd_pkg::*; #(
  parameter int N = 2,
  parameter int IW = (clog2(N) > 0) ? clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_en,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  logic [IW-1:0] r_ptr;
  always_comb begin
    logic [IW-1:0] j;
    j = '0;
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(r_ptr) + k) % N);
      if (i_req[j]) begin
        o_gnt = '0;
        o_gnt[j] = 1'b1;
        o_idx = j;
        o_any = 1'b1;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) r_ptr <= '0;
    else if (i_en) r_ptr <= o_idx;
  end
endmodule

// File: rtl/usadd_frame_sched.sv
// usadd_frame_sched: shares one unary scaled adder among NREQ requesters (iReq*/oReqReady in, oClr/oA/oB/iSum datapath, oRes* out)
module usadd_frame_sched import usadd_pkg::*; #(
  parameter int BITWIDTH = 8,
  parameter int NREQ = 2,
  parameter int LAT = 1,
  parameter int IDW = 3
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic [NREQ-1:0]          iReqValid,
  input  logic [NREQ*BITWIDTH-1:0] iReqA,
  input  logic [NREQ*BITWIDTH-1:0] iReqB,
  output logic [NREQ-1:0]          oReqReady,
  output logic                     oClr,
  output logic                     oA,
  output logic                     oB,
  input  logic                     iSum,
  output logic                     oBusy,
  output logic                     oResValid,
  output logic [BITWIDTH-1:0]      oResData,
  output logic [IDW-1:0]           oResId,
  input  logic                     iResReady
);
  localparam int IW = (clog2(NREQ) > 0) ? clog2(NREQ) : 1;
  localparam logic [BITWIDTH-1:0] CNT_LAST = BITWIDTH'(frame_len(BITWIDTH) - 1);
  localparam logic [BITWIDTH-1:0] DRAIN_LAST = BITWIDTH'(LAT - 1);
  state_t r_state;
  logic [BITWIDTH-1:0] r_a, r_b, r_cnt, r_sum;
  logic [IDW-1:0] r_id;
  logic [LAT-1:0] r_act;
  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0] w_idx;
  logic w_any, w_grant;
  logic [BITWIDTH-1:0] w_cnt_nxt, w_sum_nxt;
  assign w_grant = r_state == IDLE && w_any && !iRst;
  assign oReqReady = w_grant ? w_gnt : '0;
  assign w_cnt_nxt = r_cnt + 1'b1;
  assign w_sum_nxt = (r_act[LAT-1] && iSum && r_sum != CNT_LAST) ? r_sum + 1'b1 : r_sum;
  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .i_clk(iClk), .i_rst(iRst), .i_req(iReqValid), .i_en(w_grant),
    .o_gnt(w_gnt), .o_idx(w_idx), .o_any(w_any)
  );
  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= IDLE;
      r_a <= '0;
      r_b <= '0;
      r_cnt <= '0;
      r_sum <= '0;
      r_id <= '0;
      r_act <= '0;
      oClr <= 1'b0;
      oA <= 1'b0;
      oB <= 1'b0;
      oBusy <= 1'b0;
      oResValid <= 1'b0;
      oResData <= '0;
      oResId <= '0;
    end else begin
      // a sum bit belongs to the frame only if the stream was active LAT cycles earlier
      r_act <= LAT'({r_act, r_state == RUN});
      r_sum <= w_sum_nxt;
      case (r_state)
        IDLE: if (w_any) begin
          r_a <= iReqA[w_idx*BITWIDTH +: BITWIDTH];
          r_b <= iReqB[w_idx*BITWIDTH +: BITWIDTH];
          r_id <= IDW'(w_idx);
          r_cnt <= '0;
          r_sum <= '0;
          oClr <= 1'b1;
          oBusy <= 1'b1;
          r_state <= CLEAR;
        end
        CLEAR: begin
          oClr <= 1'b0;
          oA <= r_a != '0;
          oB <= r_b != '0;
          r_cnt <= '0;
          r_sum <= '0;
          r_state <= RUN;
        end
        RUN: begin
          oA <= r_cnt != CNT_LAST && w_cnt_nxt < r_a;
          oB <= r_cnt != CNT_LAST && w_cnt_nxt < r_b;
          r_cnt <= r_cnt == CNT_LAST ? '0 : w_cnt_nxt;
          r_state <= r_cnt == CNT_LAST ? DRAIN : RUN;
        end
        DRAIN: if (r_cnt == DRAIN_LAST) begin
          oResValid <= 1'b1;
          oResData <= w_sum_nxt;
          oResId <= r_id;
          r_state <= DONE;
        end else r_cnt <= w_cnt_nxt;
        DONE: if (iResReady) begin
          oResValid <= 1'b0;
          oResData <= '0;
          oResId <= '0;
          oBusy <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usadd_frame_sched.sv
// tb_usadd_frame_sched: randomized and directed checks of the frame scheduler against a behavioural model
module tb_usadd_frame_sched;
  localparam int BW = 4, N = 2, IDW = 3, FL = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, rr, clr, oa, ob, sum, busy, rv;
  logic [N-1:0] v, rdy;
  logic [N*BW-1:0] ra, rb;
  logic [BW-1:0] rd;
  logic [IDW-1:0] rid;
  logic v2, sum2, clr2, oa2, ob2, busy2, rv2;
  logic [BW-1:0] a2, b2, rd2;
  logic [N-1:0] rdy2;
  logic [IDW-1:0] rid2;
  int n_chk = 0, n_bad = 0;

  usadd_frame_sched #(.BITWIDTH(BW), .NREQ(N), .LAT(1), .IDW(IDW)) dut (
    .iClk(clk), .iRst(rst), .iReqValid(v), .iReqA(ra), .iReqB(rb), .oReqReady(rdy),
    .oClr(clr), .oA(oa), .oB(ob), .iSum(sum), .oBusy(busy), .oResValid(rv),
    .oResData(rd), .oResId(rid), .iResReady(rr)
  );
  usadd_frame_sched #(.BITWIDTH(BW), .NREQ(N), .LAT(3), .IDW(IDW)) dut3 (
    .iClk(clk), .iRst(rst), .iReqValid({1'b0, v2}), .iReqA({{BW{1'b0}}, a2}), .iReqB({{BW{1'b0}}, b2}),
    .oReqReady(rdy2), .oClr(clr2), .oA(oa2), .oB(ob2), .iSum(sum2), .oBusy(busy2), .oResValid(rv2),
    .oResData(rd2), .oResId(rid2), .iResReady(1'b1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // scaled adder with one cycle of latency: emits a one per two input ones, remainder discarded
  int acc = 0;
  always @(posedge clk) begin
    int s;
    s = acc + int'(oa) + int'(ob);
    if (clr) begin acc <= 0; sum <= 1'b0; end
    else begin sum <= s >= 2; acc <= s >= 2 ? s - 2 : s; end
  end

  function automatic int rr_pick(input logic [N-1:0] req, input int p);
    for (int k = 1; k <= N; k++) if (req[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  bit mon_en = 0, tb_idle = 1, after_rst = 0, res_seen = 0;
  int exp_ptr = 0, exp_a = 0, exp_b = 0, exp_id = 0, f = 0;
  logic [BW-1:0] hold_d;
  logic [IDW-1:0] hold_id;

  always @(negedge clk) if (mon_en) begin
    int w;
    logic [N-1:0] er;
    if (after_rst) begin
      chk("rst_outputs", {clr, oa, ob, busy, rv}, 0);
      chk("rst_res", {rd, rid}, 0);
    end
    after_rst = rst;
    if (rst) begin
      chk("rst_ready", rdy, 0);
      tb_idle = 1;
      exp_ptr = 0;
      res_seen = 0;
    end else begin
      w = tb_idle ? rr_pick(v, exp_ptr) : -1;
      er = (w >= 0) ? N'(1 << w) : '0;
      chk("req_ready", rdy, er);
      chk("busy", busy, !tb_idle);
      if (tb_idle) chk("idle_resvalid", rv, 0);
      else begin
        f++;
        chk("clr", clr, f == 1);
        chk("stream_a", oa, f >= 2 && f <= FL + 1 && f - 2 < exp_a);
        chk("stream_b", ob, f >= 2 && f <= FL + 1 && f - 2 < exp_b);
        if (rv) begin
          if (!res_seen) begin
            chk("latency", f, FL + 3);
            chk("res_data", rd, (exp_a + exp_b) / 2);
            chk("res_id", rid, exp_id);
            hold_d = rd;
            hold_id = rid;
            res_seen = 1;
          end else begin
            chk("hold_data", rd, hold_d);
            chk("hold_id", rid, hold_id);
          end
          if (rr) begin tb_idle = 1; res_seen = 0; end
        end
      end
      if (w >= 0) begin
        tb_idle = 0;
        exp_ptr = w;
        exp_id = w;
        exp_a = int'(ra[w*BW +: BW]);
        exp_b = int'(rb[w*BW +: BW]);
        f = 0;
      end
    end
  end

  task automatic do_req(input int i, input int a, input int b);
    int t;
    @(posedge clk); #1;
    v[i] = 1'b1;
    ra[i*BW +: BW] = BW'(a);
    rb[i*BW +: BW] = BW'(b);
    t = 0;
    do begin @(negedge clk); t++; end while (!rdy[i] && t < 100);
    chk("grant", rdy[i], 1);
    @(posedge clk); #1;
    v[i] = 1'b0;
  endtask

  task automatic wait_res();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end while (!(rv && rr) && t < 300);
    chk("result", rv && rr, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int t;
    rr = 1'b1;
    v = '0;
    t = 0;
    do begin @(negedge clk); t++; end while (busy && t < 300);
    chk("drain_idle", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic traffic(input int cycles, input int p_valid, input int p_ready);
    logic [N-1:0] g;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      g = rdy;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++)
        if (g[i] || !v[i]) begin
          v[i] = $urandom_range(99) < p_valid;
          ra[i*BW +: BW] = BW'($urandom);
          rb[i*BW +: BW] = BW'($urandom);
        end
      rr = $urandom_range(99) < p_ready;
    end
  endtask

  // LAT=3 instance: RUN sample k is qualified LAT cycles later, so frame cycles 4..19 count (0 is CLEAR)
  task automatic run3(input int mode);
    int t, k, cnt;
    logic s;
    @(posedge clk); #1;
    v2 = 1'b1;
    a2 = BW'($urandom);
    b2 = BW'($urandom);
    t = 0;
    do begin @(negedge clk); t++; end while (!rdy2[0] && t < 50);
    chk("grant3", rdy2[0], 1);
    @(posedge clk); #1;
    v2 = 1'b0;
    cnt = 0;
    for (k = 0; k < 40; k++) begin
      s = mode == 0 ? 1'b1 : mode == 1 ? logic'(k >= FL + 1) : mode == 2 ? logic'(k <= 3) : logic'($urandom_range(1));
      sum2 = s;
      if (s && k >= 4 && k <= FL + 3) cnt++;
      @(negedge clk);
      if (rv2) break;
      @(posedge clk); #1;
    end
    chk("lat3_latency", k, FL + 4);
    chk("lat3_sum", rd2, cnt > FL - 1 ? FL - 1 : cnt);
    chk("lat3_id", rid2, 0);
    @(posedge clk); #1;
    sum2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    v = '0;
    ra = '0;
    rb = '0;
    rr = 1'b1;
    v2 = 1'b0;
    a2 = '0;
    b2 = '0;
    sum2 = 1'b0;
    @(posedge clk); #1;
    mon_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_req(0, 8, 8); wait_res();
    do_req(0, 15, 0); wait_res();
    do_req(0, 0, 0); wait_res();
    traffic(200, 100, 100);
    wait_idle();
    rr = 1'b0;
    do_req(0, 5, 9);
    v[1] = 1'b1;
    ra[BW +: BW] = BW'(3);
    rb[BW +: BW] = BW'(12);
    begin
      int t;
      t = 0;
      do begin @(negedge clk); t++; end while (!rv && t < 100);
      chk("res_wait", rv, 1);
    end
    repeat (10) @(negedge clk);
    @(posedge clk); #1 rr = 1'b1;
    do_req(1, 3, 12); wait_res();
    do_req(0, 10, 6);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    do_req(0, 10, 6); wait_res();
    traffic(1500, 40, 60);
    wait_idle();
    run3(0);
    run3(1);
    run3(2);
    for (int r = 0; r < 4; r++) run3(3);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
